// File: rtl/test_status_monitor_pkg.sv
// test_status_monitor_pkg
//   Shared encodings for the end-of-test monitor. The status/state encoding
//   is also what status_o reports. FPGA tops and testbenches reuse it.
package test_status_monitor_pkg;

  // Monitor state; the encoding is the externally visible status code.
  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_PASS    = 3'd1,
    ST_FAIL    = 3'd2,
    ST_TIMEOUT = 3'd3,
    ST_HANG    = 3'd4
  } state_e;

  // PC that marks a write to tohost in the standard test environment.
  localparam logic [31:0] DEFAULT_TOHOST_PC = 32'h0000_00a0;

  // True for every state that ends the test.
  function automatic logic is_terminal(input state_e st);
    return (st != ST_RUN);
  endfunction

endpackage

// File: rtl/test_status_monitor_blink.sv
// test_status_blink
//   Free-running blink divider plus LED decode of the monitor state.
//   The divider is never cleared except by rst_n, so blink phase is
//   independent of test re-arming.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   state_i        current monitor state (registered in the parent)
//   led_pass_o     solid in PASS
//   led_fail_o     solid in FAIL, blinks in TIMEOUT and HANG
//   led_timeout_o  solid in TIMEOUT, blinks in HANG
module test_status_blink
  import test_status_monitor_pkg::*;
#(
  parameter int unsigned BLINK_DIV_W = 32'd24
) (
  input  logic   clk,
  input  logic   rst_n,
  input  state_e state_i,
  output logic   led_pass_o,
  output logic   led_fail_o,
  output logic   led_timeout_o
);

  logic [BLINK_DIV_W-1:0] div_q;
  logic [BLINK_DIV_W-1:0] div_d;
  logic                   phase_s;

  // Divider next value: plain increment, wraps naturally.
  always_comb begin
    div_d = div_q + BLINK_DIV_W'(1);
  end

  // Divider register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign phase_s = div_q[BLINK_DIV_W-1];

  // LED decode from registered state and divider only.
  always_comb begin
    led_pass_o    = 1'b0;
    led_fail_o    = 1'b0;
    led_timeout_o = 1'b0;
    case (state_i)
      ST_PASS: begin
        led_pass_o = 1'b1;
      end
      ST_FAIL: begin
        led_fail_o = 1'b1;
      end
      ST_TIMEOUT: begin
        led_fail_o    = phase_s;
        led_timeout_o = 1'b1;
      end
      ST_HANG: begin
        led_fail_o    = phase_s;
        led_timeout_o = phase_s;
      end
      default: begin
        led_pass_o    = 1'b0;
        led_fail_o    = 1'b0;
        led_timeout_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/test_status_monitor.sv
// test_status_monitor
//   End-of-test monitor placed beside the SoC. Counts distinct arrivals of
//   the fetch PC at TOHOST_PC and, once HIT_THRESHOLD is reached, judges
//   PASS/FAIL from result_i in that cycle. Also provides a cycle timeout,
//   a PC-stall (hang) detector, a frozen cycle count and blink-coded LEDs.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   pc_i         fetch PC from the core
//   result_i     result register (x3/gp)
//   clear_i      synchronous re-arm: back to RUN, counters zeroed
//   done_o       high in any terminal state
//   status_o     0=RUN 1=PASS 2=FAIL 3=TIMEOUT 4=HANG
//   cycles_o     RUN cycle count, frozen on leaving RUN
//   hits_o       tohost hit count, saturates at HIT_THRESHOLD
//   led_pass, led_fail, led_timeout   status LEDs
module test_status_monitor
  import test_status_monitor_pkg::*;
#(
  parameter logic [31:0] TOHOST_PC      = DEFAULT_TOHOST_PC,
  parameter int unsigned HIT_THRESHOLD  = 32'd8,
  parameter logic [31:0] PASS_VALUE     = 32'd1,
  parameter int unsigned CNT_W          = 32'd32,
  parameter int unsigned TIMEOUT_CYCLES = 32'd0,
  parameter int unsigned HANG_CYCLES    = 32'd4096,
  parameter int unsigned BLINK_DIV_W    = 32'd24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      result_i,
  input  logic             clear_i,
  output logic             done_o,
  output logic [2:0]       status_o,
  output logic [CNT_W-1:0] cycles_o,
  output logic [CNT_W-1:0] hits_o,
  output logic             led_pass,
  output logic             led_fail,
  output logic             led_timeout
);

  localparam logic             TIMEOUT_EN_C   = (TIMEOUT_CYCLES != 32'd0);
  localparam logic             HANG_EN_C      = (HANG_CYCLES != 32'd0);
  localparam logic [CNT_W-1:0] HIT_THR_C      = CNT_W'(HIT_THRESHOLD);
  localparam logic [CNT_W-1:0] HANG_C         = CNT_W'(HANG_CYCLES);
  // Timeout fires while cycles == TIMEOUT_CYCLES-1 so RUN lasts exactly
  // TIMEOUT_CYCLES cycles; unused (and never compared) when disabled.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST_C =
    TIMEOUT_EN_C ? CNT_W'(TIMEOUT_CYCLES - 32'd1) : '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [CNT_W-1:0] hits_q, hits_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [31:0]      last_pc_q;
  logic             hit_s;
  logic             pc_same_s;

  // A PC dwelling on tohost is one arrival, so a hit needs a PC change.
  assign pc_same_s = (pc_i == last_pc_q);
  assign hit_s     = (state_q == ST_RUN) && (pc_i == TOHOST_PC) && !pc_same_s;

  // Next state: clear_i first, then RUN exits in priority order.
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = ST_RUN;
    end else if (state_q == ST_RUN) begin
      if (hits_q == HIT_THR_C) begin
        // result_i is judged in the cycle after the final hit registered.
        state_d = (result_i == PASS_VALUE) ? ST_PASS : ST_FAIL;
      end else if (TIMEOUT_EN_C && (cycles_q == TIMEOUT_LAST_C)) begin
        state_d = ST_TIMEOUT;
      end else if (HANG_EN_C && (stall_q == HANG_C)) begin
        state_d = ST_HANG;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      // Terminal states are sticky until clear_i or rst_n.
      state_d = state_q;
    end
  end

  // Counter next values.
  always_comb begin
    cycles_d = cycles_q;
    hits_d   = hits_q;
    stall_d  = stall_q;
    if (clear_i) begin
      cycles_d = '0;
      hits_d   = '0;
      stall_d  = '0;
    end else if (state_q == ST_RUN) begin
      // Not counting the exit cycle leaves cycles_o at the value that
      // triggered the exit (e.g. TIMEOUT_CYCLES-1).
      if (state_d == ST_RUN) begin
        cycles_d = cycles_q + CNT_W'(1);
      end else begin
        cycles_d = cycles_q;
      end
      if (hit_s && (hits_q < HIT_THR_C)) begin
        hits_d = hits_q + CNT_W'(1);
      end else begin
        hits_d = hits_q;
      end
      if (!pc_same_s) begin
        stall_d = '0;
      end else if (stall_q < HANG_C) begin
        stall_d = stall_q + CNT_W'(1);
      end else begin
        stall_d = stall_q;
      end
    end else begin
      cycles_d = cycles_q;
      hits_d   = hits_q;
      stall_d  = stall_q;
    end
  end

  // State and counter registers; last_pc tracks pc_i in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      cycles_q  <= '0;
      hits_q    <= '0;
      stall_q   <= '0;
      last_pc_q <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      cycles_q  <= cycles_d;
      hits_q    <= hits_d;
      stall_q   <= stall_d;
      last_pc_q <= pc_i;
    end
  end

  assign done_o   = is_terminal(state_q);
  assign status_o = state_q;
  assign cycles_o = cycles_q;
  assign hits_o   = hits_q;

  test_status_blink #(
    .BLINK_DIV_W (BLINK_DIV_W)
  ) u_blink (
    .clk           (clk),
    .rst_n         (rst_n),
    .state_i       (state_q),
    .led_pass_o    (led_pass),
    .led_fail_o    (led_fail),
    .led_timeout_o (led_timeout)
  );

endmodule

// File: doc/test_status_monitor.md
Name: test_status_monitor

Overview:
- Parametrised end-of-test monitor for FPGA/sim tops.
- Watches the core's fetch PC and a result register (normally x3/gp).
- Counts distinct arrivals at the tohost PC and judges pass/fail once the configured hit count is reached.
- Adds a cycle-timeout watchdog, a PC-stall (hang) detector, a latched cycle count, re-arm via clear, and blink-coded LEDs.
- Instantiated beside the SoC in fpga_top-style wrappers; has no bus interface.

Parameters:
- TOHOST_PC, 32'h000000a0, PC value that marks a tohost write.
- HIT_THRESHOLD, 8, number of distinct tohost arrivals that ends the test (>=1).
- PASS_VALUE, 32'd1, result_i value meaning pass.
- CNT_W, 32, width of the cycle and hit counters.
- TIMEOUT_CYCLES, 0, cycles in RUN before TIMEOUT; 0 disables.
- HANG_CYCLES, 4096, consecutive cycles with unchanged PC before HANG; 0 disables.
- BLINK_DIV_W, 24, free-running divider width; its MSB is the blink phase.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- pc_i  in  32  current fetch PC from the core.
- result_i  in  32  result register value (x3).
- clear_i  in  1  synchronous re-arm: return to RUN and zero all counters.
- done_o  out  1  high in any terminal state.
- status_o  out  3  0=RUN, 1=PASS, 2=FAIL, 3=TIMEOUT, 4=HANG.
- cycles_o  out  CNT_W  cycle count, frozen on leaving RUN.
- hits_o  out  CNT_W  tohost hit count, saturates at HIT_THRESHOLD.
- led_pass  out  1  solid on in PASS.
- led_fail  out  1  solid in FAIL; blinks in TIMEOUT or HANG.
- led_timeout  out  1  solid in TIMEOUT; blinks in HANG.

Behaviour:
- Reset (async) values:
  - State = RUN.
  - All counters = 0, last_pc = 0, blink divider = 0.
  - All LEDs = 0, done_o = 0, status_o = 0.
- Outputs are registered or decoded from the state register only; no combinational path from pc_i.
- last_pc <= pc_i every cycle in all states.
- Hit detection:
  - A hit occurs when state==RUN, pc_i==TOHOST_PC and pc_i!=last_pc.
  - A PC that dwells on TOHOST_PC counts once.
  - The hit counter saturates at HIT_THRESHOLD.
  - After reset, a first-cycle pc_i equal to TOHOST_PC (with last_pc=0) counts as a hit unless TOHOST_PC==0.
- cycles_o increments each cycle in RUN and wraps modulo 2^CNT_W. It holds in terminal states.
- Stall counter:
  - Increments while pc_i==last_pc in RUN; clears to 0 when the PC changes.
  - Saturates at HANG_CYCLES.
- RUN exits, evaluated each cycle; priority when several are true in the same cycle is first match:
  - hits==HIT_THRESHOLD -> PASS if result_i==PASS_VALUE, else FAIL. result_i is sampled in that cycle (one cycle after the final hit registers).
  - TIMEOUT_CYCLES!=0 and cycles==TIMEOUT_CYCLES-1 -> TIMEOUT.
  - HANG_CYCLES!=0 and stall==HANG_CYCLES -> HANG.
- Terminal states:
  - PASS, FAIL, TIMEOUT and HANG are sticky. Only clear_i or rst_n leaves them.
  - done_o = 1 in every terminal state.
- clear_i:
  - Active in any state, highest priority over all RUN exits.
  - Next cycle: state = RUN, cycles/hits/stall = 0. last_pc still updates.
- Blink phase = MSB of a free-running BLINK_DIV_W counter. It runs in all states and is not cleared by clear_i.
- An async reset mid-run aborts immediately with no judgement made.

Decomposition:
- Shared package: status/state encoding constants (ST_RUN..ST_HANG, 3 bits) and the default TOHOST_PC constant. The testbench and other fpga tops reuse them.
- One natural sub-module: test_status_blink, the free-running divider plus LED decode, driven by state.
- Counters and FSM live in the top.

Test Plan:
- HIT_THRESHOLD=3, PC sequence 0x00→0xa0→0xa4→0xa0→0xa0→0xa4→0xa0, result_i=1 -> hits_o reaches 3 (the dwelling 0xa0 counted once); status_o=1, led_pass=1, done_o=1 one cycle later; cycles_o frozen.
- Same PC sequence with result_i=5 -> status_o=2, led_fail solid, led_pass=0.
- TIMEOUT_CYCLES=100, PC toggling, no tohost -> status_o=3 with cycles_o=99; led_timeout solid; led_fail toggles every 2^(BLINK_DIV_W-1) cycles (use BLINK_DIV_W=4).
- HANG_CYCLES=16, pc_i held at 0x200 -> HANG after 16 stalled cycles, status_o=4; a one-cycle PC change at stall=15 restarts the count.
- Third hit and timeout in the same cycle -> PASS/FAIL wins. Then clear_i pulse -> status_o=0, hits_o=0, cycles_o=0, and a new run completes normally.
- rst_n asserted mid-run at hits=2 -> all outputs 0 immediately (asynchronous); after release, counting restarts from 0.
